// File: rtl/lj_serial_tx_pkg.sv
// Shared definitions for the left-justified serial audio transmitter.
//   - SRAM / sample / frame-address widths
//   - channel encoding (LEFT = 1, matching LRCK high = left)
//   - SRAM region selectors for the capture and playback buffers
//   - sram_addr(): builds a read address {1'b0, channel, region, frame}
package lj_serial_tx_pkg;

  localparam int SRAM_AW  = 18;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_AW = 13;

  localparam logic CH_LEFT  = 1'b1;
  localparam logic CH_RIGHT = 1'b0;

  localparam logic [2:0] REGION_CAPTURE  = 3'b101;
  localparam logic [2:0] REGION_PLAYBACK = 3'b110;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [FRAME_AW-1:0] frame_addr_t;
  typedef logic [SRAM_AW-1:0]  sram_addr_t;

  function automatic sram_addr_t sram_addr(input logic ch,
                                           input logic [2:0] region,
                                           input frame_addr_t frame);
    return {1'b0, ch, region, frame};
  endfunction

endpackage

// File: rtl/lj_serial_tx_clock_gen.sv
// Bit/word clock generator for lj_serial_tx.
//   Clock, Reset  system clock, async active-high reset
//   run           count while high; low clears everything to 0
//   start         one-cycle strobe: begin a left slot (LRCK=1, BCK=0, bit 0)
//   bck, lrck     serial bit clock and word clock
//   fall          cycle in which BCK is being driven 1->0
//   boundary      fall on the last bit of a slot (LRCK toggles on the same edge)
module lj_serial_tx_clock_gen #(
  parameter int BCK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic Clock,
  input  logic Reset,
  input  logic run,
  input  logic start,
  output logic bck,
  output logic lrck,
  output logic fall,
  output logic boundary
);

  localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int BW = $clog2(SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_BITS - 1);

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          bck_q, bck_d;
  logic          lrck_q, lrck_d;
  logic          wrap;

  always_comb begin
    wrap     = run && (div_q == DIV_LAST);
    fall     = wrap && bck_q;
    boundary = fall && (bit_q == BIT_LAST);

    div_d  = div_q;
    bit_d  = bit_q;
    bck_d  = bck_q;
    lrck_d = lrck_q;

    if (start) begin
      div_d  = '0;
      bit_d  = '0;
      bck_d  = 1'b0;
      lrck_d = 1'b1;
    end else if (!run) begin
      div_d  = '0;
      bit_d  = '0;
      bck_d  = 1'b0;
      lrck_d = 1'b0;
    end else begin
      div_d = wrap ? '0 : div_q + 1'b1;
      if (wrap) bck_d = ~bck_q;
      if (fall) begin
        bit_d = boundary ? '0 : bit_q + 1'b1;
        if (boundary) lrck_d = ~lrck_q;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_q  <= '0;
      bit_q  <= '0;
      bck_q  <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      bck_q  <= bck_d;
      lrck_q <= lrck_d;
    end
  end

  assign bck  = bck_q;
  assign lrck = lrck_q;

endmodule

// File: rtl/lj_serial_tx.sv
// Left-justified serial audio transmitter (master mode, playback side).
// Fetches 16-bit L/R samples from the SRAM playback region and shifts them
// out MSB first, 16 data bits followed by zero padding in each LRCK half.
//   Clock, Reset   system clock, async active-high reset
//   Enable         run; low returns to idle with all outputs low
//   RdAddress/RdReq/RdAck/RdData   SRAM arbiter read port
//   BCK, LRCK, SData               DAC serial interface (LRCK high = left)
//   LastReadAddr   frame address of the last fully transmitted frame
//   Underrun       one-cycle pulse when a slot starts without a fetched sample
// Build option: define UNDERRUN_HOLD_EN to repeat the previous sample of the
// same channel on underrun instead of sending zeros.
module lj_serial_tx
  import lj_serial_tx_pkg::*;
#(
  parameter int         BCK_DIV   = 4,
  parameter logic [2:0] REGION    = REGION_PLAYBACK,
  parameter int         SLOT_BITS = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic [17:0] RdAddress,
  output logic        RdReq,
  input  logic        RdAck,
  input  logic [15:0] RdData,
  output logic        BCK,
  output logic        LRCK,
  output logic        SData,
  output logic [12:0] LastReadAddr,
  output logic        Underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [17:0] rd_addr_q, rd_addr_d;
  logic        rdreq_q, rdreq_d;
  logic [12:0] raddr_q, raddr_d;
  logic [12:0] last_q, last_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic        und_q, und_d;
`ifdef UNDERRUN_HOLD_EN
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;
`endif

  logic        ack_ok, run, start, fall, boundary, lrck;
  logic        new_ch;
  logic [12:0] raddr_next;
  logic [15:0] fill, load_val;

  lj_serial_tx_clock_gen #(
    .BCK_DIV   (BCK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clock_gen (
    .Clock    (Clock),
    .Reset    (Reset),
    .run      (run),
    .start    (start),
    .bck      (BCK),
    .lrck     (lrck),
    .fall     (fall),
    .boundary (boundary)
  );

  always_comb begin
    // Acks are only meaningful for a request we are actually holding.
    ack_ok     = RdAck && rdreq_q && Enable;
    run        = (state_q == ST_RUN) && Enable;
    start      = (state_q == ST_PRIME) && ack_ok;
    raddr_next = raddr_q + 13'd1;
    new_ch     = ~lrck;

`ifdef UNDERRUN_HOLD_EN
    fill = (new_ch == CH_LEFT) ? hold_l_q : hold_r_q;
`else
    fill = '0;
`endif
    // A sample acked in the boundary cycle itself still makes it in time.
    load_val = buf_valid_q ? buf_q : (ack_ok ? RdData : fill);

    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rdreq_d     = rdreq_q;
    raddr_d     = raddr_q;
    last_d      = last_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    und_d       = 1'b0;
`ifdef UNDERRUN_HOLD_EN
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
`endif

    if (!Enable) begin
      state_d     = ST_IDLE;
      rd_addr_d   = '0;
      rdreq_d     = 1'b0;
      raddr_d     = '0;
      last_d      = '0;
      shift_d     = '0;
      buf_d       = '0;
      buf_valid_d = 1'b0;
`ifdef UNDERRUN_HOLD_EN
      hold_l_d = '0;
      hold_r_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_PRIME;
          rdreq_d   = 1'b1;
          rd_addr_d = sram_addr(CH_LEFT, REGION, raddr_q);
        end
        ST_PRIME: begin
          if (ack_ok) begin
            state_d   = ST_RUN;
            shift_d   = RdData;
            rdreq_d   = 1'b1;
            rd_addr_d = sram_addr(CH_RIGHT, REGION, raddr_q);
`ifdef UNDERRUN_HOLD_EN
            hold_l_d = RdData;
`endif
          end
        end
        ST_RUN: begin
          if (ack_ok) begin
            buf_d       = RdData;
            buf_valid_d = 1'b1;
            rdreq_d     = 1'b0;
          end
          if (boundary) begin
            shift_d     = load_val;
            buf_valid_d = 1'b0;
            und_d       = !(buf_valid_q || ack_ok);
            // Next fetch is the channel just finished, always for frame
            // rAddress+1: during R that is the next L, and at the R->L
            // boundary rAddress itself advances to that frame.
            rdreq_d     = 1'b1;
            rd_addr_d   = sram_addr(lrck, REGION, raddr_next);
            if (new_ch == CH_LEFT) begin
              raddr_d = raddr_next;
              last_d  = raddr_q;
            end
`ifdef UNDERRUN_HOLD_EN
            if (new_ch == CH_LEFT) hold_l_d = load_val;
            else                   hold_r_d = load_val;
`endif
          end else if (fall) begin
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      rdreq_q     <= 1'b0;
      raddr_q     <= '0;
      last_q      <= '0;
      shift_q     <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      und_q       <= 1'b0;
`ifdef UNDERRUN_HOLD_EN
      hold_l_q    <= '0;
      hold_r_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rdreq_q     <= rdreq_d;
      raddr_q     <= raddr_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      und_q       <= und_d;
`ifdef UNDERRUN_HOLD_EN
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
`endif
    end
  end

  assign RdAddress    = rd_addr_q;
  assign RdReq        = rdreq_q;
  assign LRCK         = lrck;
  assign SData        = shift_q[15];
  assign LastReadAddr = last_q;
  assign Underrun     = und_q;

endmodule

// File: tb/tb_lj_serial_tx.sv
`timescale 1ns/1ps
module tb_lj_serial_tx;

  localparam int BCK_DIV = 4;
  localparam int HALF    = 64 * BCK_DIV;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        RdAck;
  logic [15:0] RdData;
  logic [17:0] RdAddress;
  logic        RdReq, BCK, LRCK, SData, Underrun;
  logic [12:0] LastReadAddr;

  lj_serial_tx #(.BCK_DIV(BCK_DIV), .REGION(3'b110), .SLOT_BITS(32)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Enable       (Enable),
    .RdAddress    (RdAddress),
    .RdReq        (RdReq),
    .RdAck        (RdAck),
    .RdData       (RdData),
    .BCK          (BCK),
    .LRCK         (LRCK),
    .SData        (SData),
    .LastReadAddr (LastReadAddr),
    .Underrun     (Underrun)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] l_data;
    logic [15:0] r_data;
    bit          r_ack;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    int          exp_und;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] l_mem[8];
  logic [15:0] r_mem[8];
  bit          r_ok[8];
  bit          sram_on   = 1'b0;
  bit          force_ack = 1'b0;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // SRAM model: one-cycle ack, R reads of frames with r_ok=0 never answered.
  always @(posedge Clock) begin
    #1;
    if (force_ack) begin
      RdAck  = 1'b1;
      RdData = 16'h0000;
    end else if (!sram_on || RdAck === 1'b1) begin
      RdAck = 1'b0;
    end else if (RdReq && (RdAddress[16] || r_ok[RdAddress[2:0]])) begin
      RdAck  = 1'b1;
      RdData = RdAddress[16] ? l_mem[RdAddress[2:0]] : r_mem[RdAddress[2:0]];
    end else begin
      RdAck = 1'b0;
    end
  end

  // Monitor: bits at BCK rise, LRCK change times, per-frame Underrun/LastReadAddr.
  bit          bits_q[$];
  bit          tags_q[$];
  int          lr_change_t[$];
  int          und_cnt[8];
  logic [12:0] lra_at[8];
  int          frame_idx = -1;
  int          cyc = 0;
  bit          chk_sd = 1'b0;
  int          sd_viol = 0;
  logic        prev_bck = 1'b0, prev_lrck = 1'b0, prev_sd = 1'b0;

  always @(negedge Clock) begin
    cyc++;
    if (BCK && !prev_bck) begin
      bits_q.push_back(SData);
      tags_q.push_back(LRCK);
    end
    if (LRCK != prev_lrck) lr_change_t.push_back(cyc);
    if (LRCK && !prev_lrck) begin
      frame_idx++;
      if (frame_idx >= 0 && frame_idx < 8) lra_at[frame_idx] = LastReadAddr;
    end
    if (Underrun && frame_idx >= 0 && frame_idx < 8) und_cnt[frame_idx]++;
    if (chk_sd && (SData != prev_sd) && !(prev_bck && !BCK)) sd_viol++;
    prev_bck  = BCK;
    prev_lrck = LRCK;
    prev_sd   = SData;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lw, lpad, rw, rpad;
    int          ltag_bad, rtag_bad, base, nbad;

    vecs[0] = '{16'hA5C3, 16'h0FF0, 1'b1, 16'hA5C3, 16'h0FF0, 0};
    vecs[1] = '{16'h1234, 16'h8001, 1'b1, 16'h1234, 16'h8001, 0};
`ifdef UNDERRUN_HOLD_EN
    vecs[2] = '{16'hFFFF, 16'h5A5A, 1'b0, 16'hFFFF, 16'h8001, 1};
`else
    vecs[2] = '{16'hFFFF, 16'h5A5A, 1'b0, 16'hFFFF, 16'h0000, 1};
`endif
    vecs[3] = '{16'h0001, 16'h7E7E, 1'b1, 16'h0001, 16'h7E7E, 0};
    vecs[4] = '{16'h8000, 16'hC3A5, 1'b1, 16'h8000, 16'hC3A5, 0};
    for (int i = 0; i < 8; i++) begin
      l_mem[i] = 16'h0000;
      r_mem[i] = 16'h0000;
      r_ok[i]  = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      l_mem[i] = vecs[i].l_data;
      r_mem[i] = vecs[i].r_data;
      r_ok[i]  = vecs[i].r_ack;
    end

    // Reset state
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("reset_outs", 32'({BCK, LRCK, SData, RdReq, Underrun}), 32'h0);
    check("reset_addr", 32'(RdAddress), 32'h0);
    check("reset_last", 32'(LastReadAddr), 32'h0);
    Reset = 1'b0;
    @(negedge Clock);

    // Prime: L read at address 0, then RUN with MSB on SData
    sram_on = 1'b1;
    Enable  = 1'b1;
    @(negedge Clock);
    check("prime_req", 32'({RdReq, RdAddress}), 32'({1'b1, 18'h1C000}));
    check("prime_idle_pins", 32'({BCK, LRCK, SData}), 32'h0);
    @(negedge Clock);
    check("run_start_pins", 32'({LRCK, SData, BCK}), 32'b110);
    check("r_fetch_addr", 32'({RdReq, RdAddress}), 32'({1'b1, 18'h0C000}));
    @(negedge Clock);
    chk_sd = 1'b1;

    for (int n = 0; n < 8000 && frame_idx < 5; n++) @(negedge Clock);
    check("frames_timeout", 32'(frame_idx >= 5), 32'h1);
    chk_sd = 1'b0;

    // Frame-by-frame comparison against the vector table
    check("bit_count", 32'(bits_q.size() >= 320), 32'h1);
    if (bits_q.size() >= 320) begin
      for (int i = 0; i < 5; i++) begin
        base = 64 * i;
        lw = '0; lpad = '0; rw = '0; rpad = '0;
        ltag_bad = 0; rtag_bad = 0;
        for (int b = 0; b < 16; b++) begin
          lw   = {lw[14:0],   bits_q[base + b]};
          lpad = {lpad[14:0], bits_q[base + 16 + b]};
          rw   = {rw[14:0],   bits_q[base + 32 + b]};
          rpad = {rpad[14:0], bits_q[base + 48 + b]};
        end
        for (int b = 0; b < 32; b++) begin
          if (tags_q[base + b] !== 1'b1)      ltag_bad++;
          if (tags_q[base + 32 + b] !== 1'b0) rtag_bad++;
        end
        check($sformatf("f%0d_left", i),  {16'(ltag_bad), lw}, {16'h0, vecs[i].exp_l});
        check($sformatf("f%0d_left_pad", i), 32'(lpad), 32'h0);
        check($sformatf("f%0d_right", i), {16'(rtag_bad), rw}, {16'h0, vecs[i].exp_r});
        check($sformatf("f%0d_right_pad", i), 32'(rpad), 32'h0);
        check($sformatf("f%0d_underrun", i), 32'(und_cnt[i]), 32'(vecs[i].exp_und));
        if (i > 0) check($sformatf("f%0d_last_addr", i), 32'(lra_at[i]), 32'(i - 1));
      end
    end

    check("lrck_changes", 32'(lr_change_t.size() >= 11), 32'h1);
    nbad = 0;
    if (lr_change_t.size() >= 11)
      for (int k = 1; k <= 10; k++)
        if (lr_change_t[k] - lr_change_t[k-1] != HALF) nbad++;
    check("lrck_period_bad", 32'(nbad), 32'h0);
    check("sdata_off_fall", 32'(sd_viol), 32'h0);

    // Enable drop, re-prime at address 0, late ack ignored
    @(negedge Clock);
    sram_on = 1'b0;
    Enable  = 1'b0;
    @(negedge Clock);
    check("drop_idle", 32'({RdReq, BCK, LRCK, SData, Underrun}), 32'h0);
    check("drop_addr", 32'(RdAddress), 32'h0);
    Enable = 1'b1;
    @(negedge Clock);
    check("reprime_req", 32'({RdReq, RdAddress, LRCK}), 32'({1'b1, 18'h1C000, 1'b0}));
    repeat (2) @(negedge Clock);
    Enable = 1'b0;
    @(negedge Clock);
    check("drop_req", 32'(RdReq), 32'h0);
    force_ack = 1'b1;
    @(negedge Clock);
    force_ack = 1'b0;
    Enable    = 1'b1;
    @(negedge Clock);
    check("late_ack_ignored", 32'({RdReq, RdAddress, LRCK}), 32'({1'b1, 18'h1C000, 1'b0}));
    @(negedge Clock);
    check("still_prime", 32'({LRCK, BCK}), 32'h0);
    sram_on = 1'b1;
    repeat (2) @(negedge Clock);
    check("restart_run", 32'({LRCK, SData}), 32'b11);

    // Reset while running
    repeat (40) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("reset_mid_outs", 32'({BCK, LRCK, SData, RdReq, Underrun}), 32'h0);
    check("reset_mid_addr", 32'({RdAddress, LastReadAddr}), 32'h0);
    Reset = 1'b0;
    @(negedge Clock);
    check("post_reset_prime", 32'({RdReq, RdAddress}), 32'({1'b1, 18'h1C000}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
